spi_adc_responder: RTL and testbench

- Synthesizable SPI slave that plays the ADC side of the command/read link: accepts an 8-bit command on MOSI and returns a 12-bit sample on MISO.
- Used as an on-chip ADC stand-in for loopback testing of the SPI master and as the FPGA-side responder when a board emulates the converter.
- All SPI inputs are oversampled by the single system clock; no logic runs on dclk.

---
 rtl/spi_adc_responder_pkg.sv | 37 +++
 rtl/spi_adc_responder_if.sv | 37 +++
 rtl/spi_adc_responder_sync_edge.sv | 46 ++++
 rtl/spi_adc_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_spi_adc_responder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_adc_pkg
//  Purpose  : Shared constants and state encoding for the SPI ADC responder.
//             Holds the default frame geometry, the synchronizer depth and
//             the explicitly sized state codes used by the responder FSM.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_adc_pkg;

    // Default frame geometry
    localparam int c_CMD_BITS   = 8;
    localparam int c_DATA_BITS  = 12;
    localparam int c_NULL_BITS  = 1;

    // Flop stages between an asynchronous pin and its first use
    localparam int c_SYNC_DEPTH = 2;

    // Responder state encoding
    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE = 3'd0;
    localparam state_t c_ST_CMD  = 3'd1;
    localparam state_t c_ST_NULL = 3'd2;
    localparam state_t c_ST_DATA = 3'd3;
    localparam state_t c_ST_DONE = 3'd4;

    // Largest of three integers; used to size the shared bit counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_adc_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_adc_responder_if
//  Purpose  : SPI pin bundle between an SPI master and the ADC responder.
//  Signals  : cs_i      - chip select, active low (master -> responder)
//             dclk_i    - SPI clock, idle low     (master -> responder)
//             mosi_i    - command data            (master -> responder)
//             miso_o    - sample data             (responder -> master)
//             miso_en_o - MISO pad drive enable   (responder -> master/pad)
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_adc_responder_if;

    logic cs_i;
    logic dclk_i;
    logic mosi_i;
    logic miso_o;
    logic miso_en_o;

    modport master (
        output cs_i,
        output dclk_i,
        output mosi_i,
        input  miso_o,
        input  miso_en_o
    );

    modport slave (
        input  cs_i,
        input  dclk_i,
        input  mosi_i,
        output miso_o,
        output miso_en_o
    );

endinterface
`default_nettype wire

// File: rtl/spi_adc_responder_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-flop synchronizer for one asynchronous input followed by
//             an edge register, giving a clean level plus single-cycle rise
//             and fall pulses in the clk domain.
//  Ports    : clk      - system clock
//             rst      - synchronous active-high reset
//             i_async  - asynchronous input pin
//             o_level  - synchronized level
//             o_rise   - one-cycle pulse on a synchronized 0->1 transition
//             o_fall   - one-cycle pulse on a synchronized 1->0 transition
//  Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   DEPTH     = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall
);

    logic [DEPTH-1:0] r_sync;
    logic             r_prev;

    // Reset loads the idle level everywhere so no edge is seen out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {DEPTH{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_async};
            r_prev <= r_sync[DEPTH-1];
        end
    end

    assign o_level = r_sync[DEPTH-1];
    assign o_rise  =  r_sync[DEPTH-1] & ~r_prev;
    assign o_fall  = ~r_sync[DEPTH-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_adc_responder
//  Purpose  : SPI mode-0 slave emulating the ADC side of a command/read link.
//             Shifts in a CMD_BITS command on MOSI, then drives NULL_BITS
//             zero bits followed by a DATA_BITS sample (MSB first) on MISO.
//             All SPI pins are oversampled by clk_i; nothing runs on dclk.
//  Ports    : clk_i       - system clock
//             rst_i       - synchronous active-high reset
//             spi         - SPI pin bundle (slave modport)
//             data_i      - sample to return, captured when the command ends
//             cmd_o       - last complete command
//             cmd_valid_o - one-cycle pulse when cmd_o updates
//             done_o      - one-cycle pulse when the master samples the LSB
//             abort_o     - one-cycle pulse when cs rises mid-frame
//  Revision : 1.0 - initial release
// ============================================================================
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int CMD_BITS  = c_CMD_BITS,
    parameter int DATA_BITS = c_DATA_BITS,
    parameter int NULL_BITS = c_NULL_BITS
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    spi_adc_responder_if.slave        spi,
    input  wire logic [DATA_BITS-1:0] data_i,
    output logic      [CMD_BITS-1:0]  cmd_o,
    output logic                      cmd_valid_o,
    output logic                      done_o,
    output logic                      abort_o
);

    localparam int c_CNT_W = $clog2(max3(CMD_BITS, DATA_BITS, NULL_BITS) + 1);

    localparam logic [c_CNT_W-1:0] c_CMD_CNT  = c_CNT_W'(CMD_BITS);
    localparam logic [c_CNT_W-1:0] c_DATA_CNT = c_CNT_W'(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_NULL_CNT = c_CNT_W'(NULL_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_unused_dclk_level, w_dclk_rise, w_dclk_fall;
    logic [c_SYNC_DEPTH-1:0] r_mosi_sync;
    logic w_mosi;

    spi_sync_edge #(
        .DEPTH     (c_SYNC_DEPTH),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_async (spi.cs_i),
        .o_level (w_cs_level),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    spi_sync_edge #(
        .DEPTH     (c_SYNC_DEPTH),
        .RESET_VAL (1'b0)
    ) u_dclk_sync (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_async (spi.dclk_i),
        .o_level (w_unused_dclk_level),
        .o_rise  (w_dclk_rise),
        .o_fall  (w_dclk_fall)
    );

    // MOSI has the same depth as dclk so the sampled bit lines up with
    // the detected rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[c_SYNC_DEPTH-2:0], spi.mosi_i};
        end
    end

    assign w_mosi = r_mosi_sync[c_SYNC_DEPTH-1];

    // ------------------------------------------------------------------
    // Frame arming: the cs synchronizer comes out of reset holding "high",
    // so a pin that is already low would look like a fresh fall. A frame
    // is only accepted once a genuine high level has been observed after
    // the synchronizer has flushed its reset contents.
    // ------------------------------------------------------------------
    logic [c_SYNC_DEPTH-1:0] r_flush;
    logic                    r_armed;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flush <= '0;
            r_armed <= 1'b0;
        end else begin
            r_flush <= {r_flush[c_SYNC_DEPTH-2:0], 1'b1};
            if (r_flush[c_SYNC_DEPTH-1] && w_cs_level) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Responder FSM and datapath
    // ------------------------------------------------------------------
    state_t                 r_state,     w_state;
    logic [c_CNT_W-1:0]     r_cnt,       w_cnt;
    logic [CMD_BITS-1:0]    r_shift_in,  w_shift_in;
    logic [DATA_BITS-1:0]   r_shift_out, w_shift_out;
    logic [CMD_BITS-1:0]    r_cmd,       w_cmd;
    logic                   r_cmd_valid, w_cmd_valid;
    logic                   r_done,      w_done;
    logic                   r_abort,     w_abort;
    logic                   r_miso,      w_miso;
    logic                   r_miso_en,   w_miso_en;
    logic [CMD_BITS-1:0]    w_cmd_next;
    logic [c_CNT_W-1:0]     w_cnt_inc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_en   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_shift_in  <= w_shift_in;
            r_shift_out <= w_shift_out;
            r_cmd       <= w_cmd;
            r_cmd_valid <= w_cmd_valid;
            r_done      <= w_done;
            r_abort     <= w_abort;
            r_miso      <= w_miso;
            r_miso_en   <= w_miso_en;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_shift_in  = r_shift_in;
        w_shift_out = r_shift_out;
        w_cmd       = r_cmd;
        w_cmd_valid = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_miso      = r_miso;
        w_miso_en   = r_miso_en;
        w_cmd_next  = {r_shift_in[CMD_BITS-2:0], w_mosi};
        w_cnt_inc   = r_cnt + c_CNT_ONE;

        // cs rise outranks any dclk edge in the same cycle
        if ((r_state != c_ST_IDLE) && w_cs_rise) begin
            w_state   = c_ST_IDLE;
            w_miso    = 1'b0;
            w_miso_en = 1'b0;
            w_abort   = (r_state != c_ST_DONE);
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    w_miso    = 1'b0;
                    w_miso_en = 1'b0;
                    if (w_cs_fall && r_armed) begin
                        w_state    = c_ST_CMD;
                        w_cnt      = '0;
                        w_shift_in = '0;
                        w_miso_en  = 1'b1;
                    end
                end

                c_ST_CMD: begin
                    if (w_dclk_rise) begin
                        w_shift_in = w_cmd_next;
                        w_cnt      = w_cnt_inc;
                        if (w_cnt_inc == c_CMD_CNT) begin
                            w_cmd       = w_cmd_next;
                            w_cmd_valid = 1'b1;
                            w_shift_out = data_i;
                            w_cnt       = '0;
                            w_state     = c_ST_NULL;
                        end
                    end
                end

                c_ST_NULL: begin
                    if (w_dclk_fall) begin
                        if (r_cnt < c_NULL_CNT) begin
                            w_miso = 1'b0;
                            w_cnt  = w_cnt_inc;
                        end else begin
                            // Counter now tracks data bits already driven
                            w_miso      = r_shift_out[DATA_BITS-1];
                            w_shift_out = {r_shift_out[DATA_BITS-2:0], 1'b0};
                            w_cnt       = c_CNT_ONE;
                            w_state     = c_ST_DATA;
                        end
                    end
                end

                c_ST_DATA: begin
                    if (w_dclk_rise && (r_cnt == c_DATA_CNT)) begin
                        // Master has just sampled the LSB
                        w_done  = 1'b1;
                        w_miso  = 1'b0;
                        w_state = c_ST_DONE;
                    end else if (w_dclk_fall && (r_cnt < c_DATA_CNT)) begin
                        w_miso      = r_shift_out[DATA_BITS-1];
                        w_shift_out = {r_shift_out[DATA_BITS-2:0], 1'b0};
                        w_cnt       = w_cnt_inc;
                    end
                end

                c_ST_DONE: begin
                    w_miso = 1'b0;
                end

                default: begin
                    w_state   = c_ST_IDLE;
                    w_miso    = 1'b0;
                    w_miso_en = 1'b0;
                end
            endcase
        end
    end

    assign spi.miso_o    = r_miso;
    assign spi.miso_en_o = r_miso_en;
    assign cmd_o         = r_cmd;
    assign cmd_valid_o   = r_cmd_valid;
    assign done_o        = r_done;
    assign abort_o       = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_adc_responder
//  Purpose  : Self-checking bench for spi_adc_responder. A mode-0 SPI master
//             task drives frames and records MISO on each dclk rise; expected
//             commands, returned words and aborts are queued when a frame is
//             issued and a monitor pops and compares them on every output
//             pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_adc_responder;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [11:0] data_i;
    logic [7:0]  cmd_o;
    logic        cmd_valid_o;
    logic        done_o;
    logic        abort_o;

    always #5 clk = ~clk;

    spi_adc_responder_if spi ();

    spi_adc_responder dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .spi         (spi),
        .data_i      (data_i),
        .cmd_o       (cmd_o),
        .cmd_valid_o (cmd_valid_o),
        .done_o      (done_o),
        .abort_o     (abort_o)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_cmd_q[$];
    logic [11:0] exp_data_q[$];
    bit          exp_abort_q[$];

    logic [31:0] rx_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame, dclk half period 8 clk. rst_at/chg_at name the rise
    // after which reset is pulsed / data_i is changed (0 = never).
    task automatic frame(input logic [7:0] cmd, input logic [11:0] data,
                         input int n_rises, input int rst_at,
                         input int chg_at, input logic [11:0] chg_val);
        data_i    = data;
        rx_word   = '0;
        spi.cs_i  = 1'b0;
        wait_clk(8);
        for (int i = 1; i <= n_rises; i++) begin
            spi.mosi_i = (i <= 8) ? cmd[8-i] : 1'b0;
            wait_clk(8);
            spi.dclk_i = 1'b1;
            rx_word    = {rx_word[30:0], spi.miso_o};
            if (i > 21) check("overclock miso", {31'd0, spi.miso_o}, 32'd0);
            if (rst_at != 0 && i > rst_at)
                check("post-reset miso_en", {31'd0, spi.miso_en_o}, 32'd0);
            if (i == chg_at) data_i = chg_val;
            if (i == rst_at) begin
                rst_i = 1'b1;
                wait_clk(1);
                rst_i = 1'b0;
                check("outputs after reset",
                      {26'd0, cmd_o, cmd_valid_o, done_o, abort_o, spi.miso_o, spi.miso_en_o},
                      32'd0);
                wait_clk(7);
            end else begin
                wait_clk(8);
            end
            spi.dclk_i = 1'b0;
        end
        wait_clk(8);
        spi.cs_i = 1'b1;
        wait_clk(3);
        check("miso_en 3 clk after cs rise", {31'd0, spi.miso_en_o}, 32'd0);
        wait_clk(29);
    endtask

    // Scoreboard monitor: every pulse must match a queued expectation
    always @(negedge clk) begin
        if (cmd_valid_o) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_valid: unexpected pulse with cmd_o=0x%0h, expected none", cmd_o);
            end else begin
                check("cmd_o", {24'd0, cmd_o}, {24'd0, exp_cmd_q.pop_front()});
            end
        end
        if (done_o) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done: unexpected pulse, rx=0x%0h, expected none", rx_word[12:0]);
            end else begin
                // Null bit then 12 data bits, as seen by the master
                check("miso word", {19'd0, rx_word[12:0]}, {20'd0, exp_data_q.pop_front()});
            end
        end
        if (abort_o) begin
            if (exp_abort_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL abort: unexpected pulse, expected none");
            end else begin
                check("abort", 32'd1, {31'd0, exp_abort_q.pop_front()});
            end
        end
    end

    initial begin
        spi.cs_i   = 1'b1;
        spi.dclk_i = 1'b0;
        spi.mosi_i = 1'b0;
        data_i     = '0;
        rst_i      = 1'b1;
        wait_clk(4);
        check("reset state",
              {26'd0, cmd_o, cmd_valid_o, done_o, abort_o, spi.miso_o, spi.miso_en_o}, 32'd0);
        rst_i = 1'b0;
        wait_clk(8);

        // Nominal frame
        exp_cmd_q.push_back(8'hA5);
        exp_data_q.push_back(12'hABC);
        frame(8'hA5, 12'hABC, 21, 0, 0, 12'h000);

        // Abort after 4 command bits
        exp_abort_q.push_back(1'b1);
        frame(8'hC3, 12'h000, 4, 0, 0, 12'h000);
        check("cmd_o held after abort", {24'd0, cmd_o}, 32'h0000_00A5);

        // Reset after 5 data bits, then a clean frame
        exp_cmd_q.push_back(8'h5A);
        frame(8'h5A, 12'h123, 21, 14, 0, 12'h000);
        exp_cmd_q.push_back(8'h3C);
        exp_data_q.push_back(12'h001);
        frame(8'h3C, 12'h001, 21, 0, 0, 12'h000);

        // data_i change during DATA must not disturb the frame
        exp_cmd_q.push_back(8'h96);
        exp_data_q.push_back(12'hFFF);
        frame(8'h96, 12'hFFF, 21, 0, 12, 12'h000);

        // Four extra dclk cycles after the LSB
        exp_cmd_q.push_back(8'h77);
        exp_data_q.push_back(12'h555);
        frame(8'h77, 12'h555, 25, 0, 0, 12'h000);

        // Back-to-back frames
        exp_cmd_q.push_back(8'h01);
        exp_data_q.push_back(12'h800);
        frame(8'h01, 12'h800, 21, 0, 0, 12'h000);
        exp_cmd_q.push_back(8'hFE);
        exp_data_q.push_back(12'h7FF);
        frame(8'hFE, 12'h7FF, 21, 0, 0, 12'h000);

        wait_clk(10);
        check("missing cmd_valid pulses", exp_cmd_q.size(),   32'd0);
        check("missing done pulses",      exp_data_q.size(),  32'd0);
        check("missing abort pulses",     exp_abort_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
